// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: registered ClkOut and Tick with period-aligned reconfiguration.
// Optional completed-period counter port PeriodCnt enabled by CLKDIV_CTRL_PERIOD_CNT_EN.
module clkdiv_ctrl #(
    parameter int   BUS_SIZE  = 8,
    parameter int   DEF_NB    = 5,
    parameter int   DEF_NBTON = 2,
    parameter logic POLARITE  = 1'b0
) (
    input  logic                ClkIn,
    input  logic                ResetN,
    input  logic                Start,
    input  logic                Stop,
    input  logic                CfgValid,
    output logic                CfgReady,
    input  logic [BUS_SIZE-1:0] CfgNb,
    input  logic [BUS_SIZE-1:0] CfgNbTon,
    output logic                CfgErr,
    output logic                ClkOut,
    output logic                Tick,
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]         PeriodCnt,
`endif
    output logic                Running
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          stateReg, stateNext;
    logic [BUS_SIZE-1:0] cntReg, cntNext;
    logic [BUS_SIZE-1:0] nbReg, nbNext;
    logic [BUS_SIZE-1:0] nbTonReg, nbTonNext;
    logic                pendValidReg, pendValidNext;
    logic [BUS_SIZE-1:0] pendNbReg, pendNbNext;
    logic [BUS_SIZE-1:0] pendNbTonReg, pendNbTonNext;
    logic                clkOutReg, clkOutNext;
    logic                tickReg, tickNext;
    logic                cfgErrReg, cfgErrNext;
    logic                xfer, legal, wrap, goRun;

    assign CfgReady = !pendValidReg;
    assign xfer     = CfgValid && !pendValidReg;
    // Nb+1 can reach 2^BUS_SIZE, so the legality check needs one extra bit
    assign legal    = ({1'b0, CfgNbTon} <= ({1'b0, CfgNb} + (BUS_SIZE+1)'(1)));
    assign wrap     = (stateReg != IDLE) && (cntReg == nbReg);
    assign goRun    = Start && !Stop;

    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        nbNext        = nbReg;
        nbTonNext     = nbTonReg;
        pendValidNext = pendValidReg;
        pendNbNext    = pendNbReg;
        pendNbTonNext = pendNbTonReg;
        tickNext      = 1'b0;
        clkOutNext    = POLARITE;
        cfgErrNext    = xfer && !legal;

        // Active config only moves while idle or exactly at a period boundary
        if (stateReg == IDLE) begin
            if (xfer && legal) begin
                nbNext    = CfgNb;
                nbTonNext = CfgNbTon;
            end
        end else if (wrap) begin
            if (xfer && legal) begin
                nbNext    = CfgNb;
                nbTonNext = CfgNbTon;
            end else if (pendValidReg) begin
                nbNext    = pendNbReg;
                nbTonNext = pendNbTonReg;
            end
            pendValidNext = 1'b0;
        end else if (xfer && legal) begin
            pendValidNext = 1'b1;
            pendNbNext    = CfgNb;
            pendNbTonNext = CfgNbTon;
        end

        case (stateReg)
            IDLE: begin
                if (goRun) begin
                    stateNext = RUN;
                    cntNext   = '0;
                    tickNext  = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (stateReg == RUN && Stop)
                    stateNext = DRAIN;
                else if (stateReg == DRAIN && goRun)
                    stateNext = RUN;
                else if (stateReg == DRAIN && wrap)
                    stateNext = IDLE;
                cntNext  = wrap ? '0 : cntReg + BUS_SIZE'(1);
                tickNext = wrap;
            end
            default: stateNext = IDLE;
        endcase

        if (stateNext == IDLE) begin
            cntNext  = '0;
            tickNext = 1'b0;
        end else begin
            clkOutNext = (cntNext < nbTonNext) ? POLARITE : ~POLARITE;
        end
    end

    always_ff @(posedge ClkIn or negedge ResetN) begin
        if (!ResetN) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            nbReg        <= BUS_SIZE'(DEF_NB);
            nbTonReg     <= BUS_SIZE'(DEF_NBTON);
            pendValidReg <= 1'b0;
            pendNbReg    <= '0;
            pendNbTonReg <= '0;
            clkOutReg    <= POLARITE;
            tickReg      <= 1'b0;
            cfgErrReg    <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            nbReg        <= nbNext;
            nbTonReg     <= nbTonNext;
            pendValidReg <= pendValidNext;
            pendNbReg    <= pendNbNext;
            pendNbTonReg <= pendNbTonNext;
            clkOutReg    <= clkOutNext;
            tickReg      <= tickNext;
            cfgErrReg    <= cfgErrNext;
        end
    end

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    logic [15:0] periodCntReg;

    always_ff @(posedge ClkIn or negedge ResetN) begin
        if (!ResetN)
            periodCntReg <= '0;
        else if (stateReg == IDLE && goRun)
            periodCntReg <= '0;
        else if (wrap)
            periodCntReg <= periodCntReg + 16'd1;
    end

    assign PeriodCnt = periodCntReg;
`endif

    assign ClkOut  = clkOutReg;
    assign Tick    = tickReg;
    assign CfgErr  = cfgErrReg;
    assign Running = (stateReg != IDLE);

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: a vector table plus hand sequences for reset and Nb=0.
module tb_clkdiv_ctrl;

    logic       ClkIn = 1'b0;
    logic       ResetN = 1'b0;
    logic       Start = 1'b0, Stop = 1'b0, CfgValid = 1'b0;
    logic [7:0] CfgNb = '0, CfgNbTon = '0;
    logic       CfgReady, CfgErr, ClkOut, Tick, Running;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    logic [15:0] PeriodCnt;
`endif

    int asserts = 0;
    int failures = 0;

    always #5 ClkIn = ~ClkIn;

    clkdiv_ctrl #(.BUS_SIZE(8), .DEF_NB(5), .DEF_NBTON(2), .POLARITE(1'b0)) dut (
        .ClkIn(ClkIn), .ResetN(ResetN), .Start(Start), .Stop(Stop),
        .CfgValid(CfgValid), .CfgReady(CfgReady), .CfgNb(CfgNb), .CfgNbTon(CfgNbTon),
        .CfgErr(CfgErr), .ClkOut(ClkOut), .Tick(Tick),
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        .PeriodCnt(PeriodCnt),
`endif
        .Running(Running)
    );

    typedef struct {
        logic       start, stop, cv;
        logic [7:0] nb, ton;
        logic       clk, tick, run, rdy, err;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic s, input logic p, input logic c,
                              input logic [7:0] n, input logic [7:0] t,
                              input logic ck, input logic tk, input logic r,
                              input logic rd, input logic e);
        vec_t x;
        x.start = s; x.stop = p; x.cv = c; x.nb = n; x.ton = t;
        x.clk = ck; x.tick = tk; x.run = r; x.rdy = rd; x.err = e;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int idx, input logic ck, input logic tk,
                            input logic r, input logic rd, input logic e);
        check({tag, " ClkOut"}, idx, 16'(ClkOut), 16'(ck));
        check({tag, " Tick"}, idx, 16'(Tick), 16'(tk));
        check({tag, " Running"}, idx, 16'(Running), 16'(r));
        check({tag, " CfgReady"}, idx, 16'(CfgReady), 16'(rd));
        check({tag, " CfgErr"}, idx, 16'(CfgErr), 16'(e));
        $display("%s step %0d: ClkOut=%0b Tick=%0b Running=%0b CfgReady=%0b CfgErr=%0b",
                 tag, idx, ClkOut, Tick, Running, CfgReady, CfgErr);
    endtask

    task automatic step();
        @(posedge ClkIn);
        #1;
    endtask

    task automatic drive(input logic s, input logic p, input logic c,
                         input logic [7:0] n, input logic [7:0] t);
        Start = s; Stop = p; CfgValid = c; CfgNb = n; CfgNbTon = t;
    endtask

    initial begin
        // defaults 5,2: ClkOut 0,0,1,1,1,1
        v(1,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        // illegal 3,5 rejected; legal 3,4 pending until wrap
        v(0,0,1,3,5, 1,0,1,1,1);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,1,3,4, 1,0,1,0,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        // switch to 3,1
        v(0,0,1,3,1, 0,0,1,0,0);
        v(0,0,0,0,0, 0,0,1,0,0);
        v(0,0,0,0,0, 0,0,1,0,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        // 7,4 offered mid-period: current period still 4 cycles
        v(0,0,1,7,4, 1,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        // back to 5,2
        v(0,0,1,5,2, 0,0,1,0,0);
        v(0,0,0,0,0, 0,0,1,0,0);
        v(0,0,0,0,0, 0,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 1,0,1,0,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        // Stop at cnt=1: drain to end of period, then idle
        v(0,1,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 0,0,0,1,0);
        v(0,0,0,0,0, 0,0,0,1,0);
        // restart, Stop, then Start during DRAIN keeps running
        v(1,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        v(0,1,0,0,0, 1,0,1,1,0);
        v(1,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 0,1,1,1,0);
        v(0,0,0,0,0, 0,0,1,1,0);
        // Stop wins over Start
        v(1,1,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 0,0,0,1,0);
        v(1,1,0,0,0, 0,0,0,1,0);
        v(0,0,0,0,0, 0,0,0,1,0);
        // IDLE cfg 2,0 with Start: first period already uses it (never POLARITE)
        v(1,0,1,2,0, 1,1,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,0,1,1,0);
        v(0,0,0,0,0, 1,1,1,1,0);
        // DRAIN with a pending config
        v(0,1,0,0,0, 1,0,1,1,0);
        v(0,0,1,4,1, 1,0,1,0,0);

        step();
        checkAll("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ResetN = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].cv, vecs[i].nb, vecs[i].ton);
            step();
            checkAll("vec", i, vecs[i].clk, vecs[i].tick, vecs[i].run, vecs[i].rdy, vecs[i].err);
        end
        drive(0, 0, 0, 0, 0);

        // asynchronous reset in DRAIN with pending config
        ResetN = 1'b0;
        #1;
        checkAll("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkAll("async_rst", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ResetN = 1'b1;
        drive(1, 0, 0, 0, 0);
        step();
        checkAll("post_rst", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            checkAll("post_rst", k, ((k % 6) >= 2), ((k % 6) == 0), 1'b1, 1'b1, 1'b0);
        end

        // Nb=0: Tick every cycle, ClkOut stays at POLARITE with NbTon=1
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        drive(1, 0, 1, 0, 1);
        step();
        checkAll("nb0", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        check("nb0 PeriodCnt", 0, PeriodCnt, 16'd0);
`endif
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            checkAll("nb0", k, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
            check("nb0 PeriodCnt", k, PeriodCnt, 16'(k));
`endif
        end
        drive(0, 1, 0, 0, 0);
        step();
        checkAll("nb0_stop", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0);
        step();
        checkAll("nb0_stop", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        check("nb0 PeriodCnt idle", 1, PeriodCnt, 16'd6);
`endif
        drive(1, 0, 0, 0, 0);
        step();
        checkAll("nb0_restart", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        check("nb0 PeriodCnt restart", 0, PeriodCnt, 16'd0);
`endif
        drive(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
